// File: rtl/pipeline_fetch_stage_pkg.sv
// Shared fetch-stage types: FSM states, IF/ID record, defaults.
// Also used by the decode stage for the IF/ID bundle.
package pipeline_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/pipeline_fetch_stage_if.sv
// Instruction-memory fetch handshake (req held until ack).
// master = fetch stage, slave = memory.
interface pipeline_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pipeline_fetch_stage_skid.sv
// One-entry skid buffer parking a fetched word while ID stalls.
// Clear wins over load, load wins over unload.
module fetch_skid_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic        unload,
  input  logic [31:0] din_instr,
  input  logic [31:0] din_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Entry register with its occupancy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= din_instr;
      pc    <= din_pc;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_fetch_stage.sv
// IF stage: PC, imem req/ack fetch FSM, IF/ID register.
// Handles ID stall (skid) and branch redirect (flush/drop).
module pipeline_fetch_stage
  import pipeline_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_fetch_stage_if.master imem,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  ifid_valid,
  output logic [31:0]           ifid_instr,
  output logic [31:0]           ifid_pc,
  output logic [31:0]           ifid_pc_plus4
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  drop_addr;
  if_id_t       ifid;

  logic [31:0]  tgt;
  logic [31:0]  pc4;
  logic         ack;
  logic         sk_valid;
  logic [31:0]  sk_instr;
  logic [31:0]  sk_pc;
  logic         sk_load;
  logic         sk_clear;
  logic         sk_unload;

  assign tgt = word_align(redirect_pc);
  assign pc4 = pc + 32'd4;
  assign ack = imem.imem_ack;

  assign imem.imem_req  = (state == REQ) || (state == DROP);
  assign imem.imem_addr = (state == DROP) ? drop_addr : pc;

  assign sk_load   = (state == REQ) && ack && stall && !redirect;
  assign sk_clear  = (state == HOLD) && redirect;
  assign sk_unload = (state == HOLD) && !redirect && !stall;

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (sk_load),
    .clear     (sk_clear),
    .unload    (sk_unload),
    .din_instr (imem.imem_rdata),
    .din_pc    (pc),
    .valid     (sk_valid),
    .instr     (sk_instr),
    .pc        (sk_pc)
  );

  // Fetch FSM with PC and IF/ID register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
      ifid      <= '{1'b0, NOP_INSTR, 32'h0, 32'h0};
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (redirect) begin
            ifid.valid <= 1'b0;
            pc         <= tgt;
            drop_addr  <= pc;
            state      <= ack ? REQ : DROP;
          end else if (ack && !stall) begin
            ifid <= '{1'b1, imem.imem_rdata, pc, pc4};
            pc   <= pc4;
          end else if (ack) begin
            state <= HOLD;
          end else if (!stall) begin
            ifid.valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            ifid.valid <= 1'b0;
            pc         <= tgt;
            state      <= REQ;
          end else if (!stall) begin
            ifid  <= '{sk_valid, sk_instr, sk_pc, sk_pc + 32'd4};
            pc    <= pc4;
            state <= REQ;
          end
        end
        DROP: begin
          if (redirect) pc <= tgt;
          if (ack) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ifid_valid    = ifid.valid;
  assign ifid_instr    = ifid.valid ? ifid.instr : NOP_INSTR;
  assign ifid_pc       = ifid.pc;
  assign ifid_pc_plus4 = ifid.pc_plus4;

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Bench for pipeline_fetch_stage: directed table, corner
// sequences and a random run against an instruction-stream model.
module tb_pipeline_fetch_stage;

  function automatic logic [31:0] w(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] rpc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;

  int   total = 0;
  int   bad = 0;
  int   ws = 0;
  int   cnt;
  logic rmode = 1'b0;
  logic rnd;

  pipeline_fetch_stage_if bus();

  assign bus.imem_ack   = bus.imem_req && (rmode ? rnd : (cnt == ws));
  assign bus.imem_rdata = w(bus.imem_addr);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 0;
      rnd <= 1'b0;
    end else begin
      rnd <= 1'($urandom_range(1, 0));
      cnt <= (bus.imem_req && !bus.imem_ack) ? cnt + 1 : 0;
    end
  end

  pipeline_fetch_stage #(
    .RESET_PC  (32'h0),
    .NOP_INSTR (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (bus),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (rpc),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4)
  );

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic s, logic r, logic [31:0] t,
                              logic q, logic [31:0] a,
                              logic v, logic [31:0] p);
    vec_t x;
    x.stall = s; x.redirect = r; x.rpc = t;
    x.req = q; x.addr = a; x.valid = v; x.pc = p;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    rpc = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_slot(input string nm, input logic [31:0] p);
    chk({nm, " valid"}, 32'(ifid_valid), 1);
    chk({nm, " pc"}, ifid_pc, p);
    chk({nm, " instr"}, ifid_instr, w(p));
    chk({nm, " pc4"}, ifid_pc_plus4, p + 32'd4);
  endtask

  logic        p_valid, p_req, p_ack;
  logic [31:0] p_instr, p_pc, p_addr;
  logic [31:0] exp_pc;
  int          idle;

  initial begin
    tbl[0]  = mk(0, 0, 0,     1, 32'h00, 0, 0);
    tbl[1]  = mk(0, 0, 0,     1, 32'h04, 1, 32'h00);
    tbl[2]  = mk(0, 0, 0,     1, 32'h08, 1, 32'h04);
    tbl[3]  = mk(1, 0, 0,     0, 0,      1, 32'h04);
    tbl[4]  = mk(1, 0, 0,     0, 0,      1, 32'h04);
    tbl[5]  = mk(1, 0, 0,     0, 0,      1, 32'h04);
    tbl[6]  = mk(1, 0, 0,     0, 0,      1, 32'h04);
    tbl[7]  = mk(0, 0, 0,     1, 32'h0C, 1, 32'h08);
    tbl[8]  = mk(0, 0, 0,     1, 32'h10, 1, 32'h0C);
    tbl[9]  = mk(1, 1, 32'h80, 1, 32'h80, 0, 0);
    tbl[10] = mk(0, 0, 0,     1, 32'h84, 1, 32'h80);
    tbl[11] = mk(1, 0, 0,     0, 0,      1, 32'h80);
    tbl[12] = mk(1, 1, 32'h33, 1, 32'h30, 0, 0);
    tbl[13] = mk(0, 0, 0,     1, 32'h34, 1, 32'h30);
    tbl[14] = mk(0, 0, 0,     1, 32'h38, 1, 32'h34);

    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    rpc = '0;
    #3;
    chk("rst req", 32'(bus.imem_req), 0);
    chk("rst valid", 32'(ifid_valid), 0);
    chk("rst instr", ifid_instr, 0);
    chk("rst pc", ifid_pc, 0);
    chk("rst pc4", ifid_pc_plus4, 0);

    // zero-wait back-to-back fetch
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("t1 req", 32'(bus.imem_req), 1);
    chk("t1 addr", bus.imem_addr, 0);
    chk("t1 valid0", 32'(ifid_valid), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_slot("t1", 32'(4 * k));
    end

    // stall into HOLD, redirects in REQ and HOLD
    do_reset();
    for (int i = 0; i < 15; i++) begin
      stall = tbl[i].stall;
      redirect = tbl[i].redirect;
      rpc = tbl[i].rpc;
      step();
      chk($sformatf("tbl%0d req", i), 32'(bus.imem_req), 32'(tbl[i].req));
      if (tbl[i].req)
        chk($sformatf("tbl%0d addr", i), bus.imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d valid", i), 32'(ifid_valid),
          32'(tbl[i].valid));
      if (tbl[i].valid) chk_slot($sformatf("tbl%0d", i), tbl[i].pc);
      else chk($sformatf("tbl%0d nop", i), ifid_instr, 0);
    end
    stall = 1'b0;
    redirect = 1'b0;

    // two wait states
    ws = 2;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        chk("t2 req", 32'(bus.imem_req), 1);
        chk("t2 addr", bus.imem_addr, 32'(4 * k));
        chk("t2 valid", 32'(ifid_valid), 32'(c == 0 && k > 0));
        if (c == 0 && k > 0) chk_slot("t2", 32'(4 * (k - 1)));
      end
    end

    // redirect with request to 0x10 outstanding
    step();
    chk("t4 addr", bus.imem_addr, 32'h10);
    chk_slot("t4 pre", 32'h0C);
    redirect = 1'b1;
    rpc = 32'h40;
    step();
    redirect = 1'b0;
    chk("t4 valid", 32'(ifid_valid), 0);
    chk("t4 hold addr", bus.imem_addr, 32'h10);
    chk("t4 hold req", 32'(bus.imem_req), 1);
    step();
    chk("t4 hold addr2", bus.imem_addr, 32'h10);
    chk("t4 ack", 32'(bus.imem_ack), 1);
    step();
    chk("t4 new addr", bus.imem_addr, 32'h40);
    chk("t4 dropped", 32'(ifid_valid), 0);
    repeat (2) step();
    chk("t4 bubble", 32'(ifid_valid), 0);
    step();
    chk_slot("t4 tgt", 32'h40);

    // async reset mid-request
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("t6 rst req", 32'(bus.imem_req), 0);
    chk("t6 rst valid", 32'(ifid_valid), 0);
    chk("t6 rst instr", ifid_instr, 0);
    chk("t6 rst pc", ifid_pc, 0);
    chk("t6 rst pc4", ifid_pc_plus4, 0);

    // PC wrap
    ws = 0;
    @(negedge clk);
    reset = 1'b1;
    step();
    redirect = 1'b1;
    rpc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    chk("t6 wrap addr", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    chk_slot("t6 wrap", 32'hFFFF_FFFC);
    chk("t6 wrap next", bus.imem_addr, 32'h0);
    step();
    chk_slot("t6 after", 32'h0);

    // random: ID-side stream must be exact, modulo flushes
    rmode = 1'b1;
    do_reset();
    step();
    exp_pc = 32'h0;
    idle = 0;
    for (int i = 0; i < 2000; i++) begin
      stall = ($urandom_range(9, 0) < 3);
      redirect = ($urandom_range(19, 0) == 0);
      rpc = $urandom;
      if ($urandom_range(3, 0) == 0) rpc = rpc | 32'hFFFF_FFE0;
      p_valid = ifid_valid;
      p_instr = ifid_instr;
      p_pc = ifid_pc;
      p_req = bus.imem_req;
      p_ack = bus.imem_ack;
      p_addr = bus.imem_addr;
      step();
      idle++;
      if (redirect) begin
        exp_pc = rpc & ~32'h3;
        chk("rnd flush", 32'(ifid_valid), 0);
        idle = 0;
      end else if (p_valid && stall) begin
        chk("rnd stall valid", 32'(ifid_valid), 1);
        chk("rnd stall pc", ifid_pc, p_pc);
        chk("rnd stall instr", ifid_instr, p_instr);
      end else if (p_valid) begin
        chk("rnd stream pc", p_pc, exp_pc);
        chk("rnd stream instr", p_instr, w(exp_pc));
        exp_pc = exp_pc + 32'd4;
        idle = 0;
      end
      if (p_req && !p_ack) begin
        chk("rnd req held", 32'(bus.imem_req), 1);
        chk("rnd addr held", bus.imem_addr, p_addr);
      end
      if (ifid_valid) chk("rnd pc4", ifid_pc_plus4, ifid_pc + 32'd4);
      else chk("rnd nop", ifid_instr, 0);
      if (idle > 80) begin
        total++;
        bad++;
        $display("FAIL rnd progress: got %0d idle cycles want <= 80",
                 idle);
        break;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
